// File: rtl/datapath_sequencer.sv
// datapath_sequencer: multi-cycle control unit for the 8-bit-instruction
// datapath. Owns pc and ir, sequences FETCH/DECODE/EXEC/WB, and shares the
// register-file write port between core writeback and a host preload port.
module datapath_sequencer #(
  parameter int PC_WIDTH  = 4,
  parameter int LAST_PC   = 3,
  parameter int ALU_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 step,
  input  logic                 halt_req,
  input  logic [7:0]           ins_in,
  input  logic [ALU_WIDTH-1:0] alu_result,
  input  logic                 host_wr_req,
  input  logic [1:0]           host_wr_sel,
  input  logic [ALU_WIDTH-1:0] host_wr_data,
  output logic [PC_WIDTH-1:0]  pc,
  output logic [1:0]           rf_sel1,
  output logic [1:0]           rf_sel2,
  output logic [1:0]           alu_opcode,
  output logic                 rf_we,
  output logic [1:0]           rf_wsel,
  output logic [ALU_WIDTH-1:0] rf_wdata,
  output logic                 host_wr_ack,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           instr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_DONE
  } state_t;

  localparam logic [PC_WIDTH-1:0] LAST = PC_WIDTH'(LAST_PC);

  state_t               state;
  logic [7:0]           ir;
  logic [ALU_WIDTH-1:0] res;
  logic                 step_mode;
  logic                 halt_pend;
  logic                 host_grant;
  logic                 in_flight;

  // Host owns the write port only while the core is idle; reset blocks it so
  // nothing is written while reset is held.
  assign host_grant = (state == S_IDLE) && host_wr_req && !reset;
  assign in_flight  = (state == S_FETCH) || (state == S_DECODE) ||
                      (state == S_EXEC)  || (state == S_WB);

  assign rf_sel1     = ir[3:2];
  assign rf_sel2     = ir[5:4];
  assign alu_opcode  = ir[1:0];
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign host_wr_ack = host_grant;

  // Write-port mux: host grant and core WB are mutually exclusive by state.
  always_comb begin
    rf_we    = 1'b0;
    rf_wsel  = 2'b00;
    rf_wdata = '0;
    if (host_grant) begin
      rf_we    = 1'b1;
      rf_wsel  = host_wr_sel;
      rf_wdata = host_wr_data;
    end else if (state == S_WB) begin
      rf_we    = 1'b1;
      rf_wsel  = ir[7:6];
      rf_wdata = res;
    end
  end

  // Main sequencer: state, pc, ir, result latch, retire counter and halt flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= '0;
      ir          <= '0;
      res         <= '0;
      instr_count <= '0;
      step_mode   <= 1'b0;
      halt_pend   <= 1'b0;
    end else begin
      if (in_flight && halt_req) begin
        halt_pend <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (host_wr_req) begin
            state <= S_IDLE;
          end else if (start) begin
            pc          <= '0;
            instr_count <= '0;
            step_mode   <= 1'b0;
            state       <= S_FETCH;
          end else if (step) begin
            step_mode <= 1'b1;
            state     <= S_FETCH;
          end
        end
        S_FETCH: begin
          ir    <= ins_in;
          state <= S_DECODE;
        end
        S_DECODE: begin
          state <= S_EXEC;
        end
        S_EXEC: begin
          res   <= alu_result;
          state <= S_WB;
        end
        S_WB: begin
          if (instr_count != 8'hFF) begin
            instr_count <= instr_count + 8'd1;
          end
          if (step_mode) begin
            pc    <= (pc == LAST) ? '0 : pc + 1'b1;
            state <= S_DONE;
          end else if ((pc == LAST) || halt_pend || halt_req) begin
            state <= S_DONE;
          end else begin
            pc    <= pc + 1'b1;
            state <= S_FETCH;
          end
        end
        S_DONE: begin
          halt_pend <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer: scoreboard bench with an instruction-level reference
// model, a behavioural register file / ALU / instruction memory around the DUT.
module tb_datapath_sequencer;

  localparam int PW = 4;
  localparam int LP = 3;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          step = 1'b0;
  logic          halt_req = 1'b0;
  logic [7:0]    ins_in;
  logic [AW-1:0] alu_result;
  logic          host_wr_req = 1'b0;
  logic [1:0]    host_wr_sel = 2'b00;
  logic [AW-1:0] host_wr_data = '0;
  logic [PW-1:0] pc;
  logic [1:0]    rf_sel1, rf_sel2, alu_opcode, rf_wsel;
  logic          rf_we, host_wr_ack, busy, done;
  logic [AW-1:0] rf_wdata;
  logic [7:0]    instr_count;

  datapath_sequencer #(.PC_WIDTH(PW), .LAST_PC(LP), .ALU_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .step(step), .halt_req(halt_req),
    .ins_in(ins_in), .alu_result(alu_result), .host_wr_req(host_wr_req),
    .host_wr_sel(host_wr_sel), .host_wr_data(host_wr_data), .pc(pc),
    .rf_sel1(rf_sel1), .rf_sel2(rf_sel2), .alu_opcode(alu_opcode),
    .rf_we(rf_we), .rf_wsel(rf_wsel), .rf_wdata(rf_wdata),
    .host_wr_ack(host_wr_ack), .busy(busy), .done(done),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    sel;
    logic [AW-1:0] data;
    int            cyc;
  } wr_t;

  typedef struct {
    logic [PW-1:0] pc;
    logic [7:0]    cnt;
    int            cyc;
  } done_t;

  wr_t   exp_wr[$];
  wr_t   exp_ack[$];
  done_t exp_done[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;

  // Surrounding datapath: instruction memory, register file and ALU.
  logic [7:0]    prog[16];
  logic [AW-1:0] rf[4];
  logic [AW-1:0] m_regs[4];
  logic [PW-1:0] m_pc;
  logic [7:0]    m_cnt;

  function automatic logic [AW-1:0] alu_ref(input logic [1:0] op,
                                            input logic [AW-1:0] a,
                                            input logic [AW-1:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a ^ b;
    endcase
  endfunction

  assign ins_in     = prog[pc];
  assign alu_result = alu_ref(alu_opcode, rf[rf_sel1], rf[rf_sel2]);

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (rf_we) rf[rf_wsel] <= rf_wdata;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic report_unexpected(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: actual event required none (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes or signals done.
  always @(negedge clk) begin
    wr_t   w;
    done_t d;
    if (!reset) begin
      if (host_wr_ack) begin
        if (exp_ack.size() == 0) report_unexpected("host_ack");
        else begin
          w = exp_ack.pop_front();
          checkOutput("host_we", {31'b0, rf_we}, 32'd1);
          checkOutput("host_wsel", {30'b0, rf_wsel}, {30'b0, w.sel});
          checkOutput("host_wdata", {16'b0, rf_wdata}, {16'b0, w.data});
          checkOutput("host_cycle", cyc, w.cyc);
        end
      end else if (rf_we) begin
        if (exp_wr.size() == 0) report_unexpected("core_wb");
        else begin
          w = exp_wr.pop_front();
          checkOutput("wb_sel", {30'b0, rf_wsel}, {30'b0, w.sel});
          checkOutput("wb_data", {16'b0, rf_wdata}, {16'b0, w.data});
          checkOutput("wb_cycle", cyc, w.cyc);
        end
      end
      if (done) begin
        if (exp_done.size() == 0) report_unexpected("done");
        else begin
          d = exp_done.pop_front();
          checkOutput("done_pc", {28'b0, pc}, {28'b0, d.pc});
          checkOutput("done_count", {24'b0, instr_count}, {24'b0, d.cnt});
          checkOutput("done_cycle", cyc, d.cyc);
        end
      end
    end
  end

  // Reference model: one instruction at the current model pc.
  task automatic model_exec(input int wb_cyc);
    logic [7:0]    ins;
    logic [AW-1:0] r;
    ins = prog[m_pc];
    r   = alu_ref(ins[1:0], m_regs[ins[3:2]], m_regs[ins[5:4]]);
    exp_wr.push_back('{ins[7:6], r, wb_cyc});
    m_regs[ins[7:6]] = r;
    if (m_cnt != 8'hFF) m_cnt++;
  endtask

  // Reference model of a run started at cycle s; h>0 is the cycle holding halt_req.
  task automatic model_run(input int s, input int h);
    int n = 0;
    m_pc  = '0;
    m_cnt = '0;
    for (int k = 0; k < 16; k++) begin
      model_exec(s + 4 * n + 4);
      n++;
      if (m_pc == PW'(LP) || (h > 0 && (h - 1) / 4 == n - 1)) break;
      m_pc++;
    end
    exp_done.push_back('{m_pc, m_cnt, s + 4 * n + 1});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic st, input logic h,
                               input logic hreq, input logic [1:0] hsel,
                               input logic [AW-1:0] hdata);
    start        = s;
    step         = st;
    halt_req     = h;
    host_wr_req  = hreq;
    host_wr_sel  = hsel;
    host_wr_data = hdata;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400; i++) begin
      if (!busy) return;
      tick();
    end
    report_unexpected({name, "_timeout"});
  endtask

  task automatic host_write(input logic [1:0] sel, input logic [AW-1:0] data);
    exp_ack.push_back('{sel, data, cyc});
    m_regs[sel] = data;
    applyStimulus(0, 0, 0, 1, sel, data);
    tick();
    applyStimulus(0, 0, 0, 0, 2'b00, '0);
  endtask

  task automatic do_run(input int h);
    int s = cyc;
    model_run(s, h);
    applyStimulus(1, 0, 0, 0, 2'b00, '0);
    tick();
    applyStimulus(0, 0, 0, 0, 2'b00, '0);
    if (h > 0) begin
      for (int i = 0; i < 40 && cyc < s + h; i++) tick();
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
    end
    wait_idle("run");
  endtask

  task automatic do_step;
    int s = cyc;
    model_exec(s + 4);
    m_pc = (m_pc == PW'(LP)) ? '0 : m_pc + 1'b1;
    exp_done.push_back('{m_pc, m_cnt, s + 5});
    applyStimulus(0, 1, 0, 0, 2'b00, '0);
    tick();
    applyStimulus(0, 0, 0, 0, 2'b00, '0);
    wait_idle("step");
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s;
    for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
    m_pc  = '0;
    m_cnt = '0;
    tick();
    tick();
    checkOutput("reset_pc", {28'b0, pc}, 32'd0);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_done", {31'b0, done}, 32'd0);
    checkOutput("reset_we", {31'b0, rf_we}, 32'd0);
    checkOutput("reset_ack", {31'b0, host_wr_ack}, 32'd0);
    checkOutput("reset_wsel", {30'b0, rf_wsel}, 32'd0);
    checkOutput("reset_wdata", {16'b0, rf_wdata}, 32'd0);
    checkOutput("reset_count", {24'b0, instr_count}, 32'd0);
    reset = 1'b0;
    tick();

    // Preload every register, then r1 = r0 + r1 with r0=5, r1=3.
    host_write(2'd2, 16'h1234);
    host_write(2'd3, 16'h00F0);
    host_write(2'd0, 16'd5);
    host_write(2'd1, 16'd3);
    prog[0] = 8'h44;
    do_step();
    checkOutput("add_r1", {16'b0, rf[1]}, 32'd8);
    checkOutput("step_pc", {28'b0, pc}, 32'd1);

    // Full run: WB at 4,8,12,16 and done at 17 relative to start.
    prog[1] = 8'hB1;
    prog[2] = 8'h2E;
    prog[3] = 8'hD3;
    do_run(0);
    checkOutput("run_end_pc", {28'b0, pc}, 32'd3);
    checkOutput("run_count", {24'b0, instr_count}, 32'd4);

    // Reset during EXEC of instruction 1: only instruction 0 writes back.
    s = cyc;
    m_pc = '0;
    m_cnt = '0;
    model_exec(s + 4);
    applyStimulus(1, 0, 0, 0, 2'b00, '0);
    tick();
    applyStimulus(0, 0, 0, 0, 2'b00, '0);
    for (int i = 0; i < 20 && cyc < s + 7; i++) tick();
    checkOutput("pre_reset_pc", {28'b0, pc}, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("mid_reset_pc", {28'b0, pc}, 32'd0);
    checkOutput("mid_reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("mid_reset_we", {31'b0, rf_we}, 32'd0);
    checkOutput("mid_reset_count", {24'b0, instr_count}, 32'd0);
    tick();
    reset = 1'b0;
    m_pc = '0;
    m_cnt = '0;
    for (int i = 0; i < 8; i++) tick();
    checkOutput("post_reset_busy", {31'b0, busy}, 32'd0);

    // Four steps walk pc 0->1->2->3 then wrap to 0.
    for (int i = 0; i < 4; i++) begin
      do_step();
      checkOutput("walk_pc", {28'b0, pc}, (i == 3) ? 32'd0 : i + 1);
    end

    // Halt held during DECODE of instruction 1.
    do_run(6);
    checkOutput("halt_count", {24'b0, instr_count}, 32'd2);
    checkOutput("halt_pc", {28'b0, pc}, 32'd1);

    // Host request while busy waits for the first IDLE cycle.
    s = cyc;
    model_run(s, 0);
    applyStimulus(1, 0, 0, 0, 2'b00, '0);
    tick();
    applyStimulus(0, 0, 0, 1, 2'd2, 16'hBEEF);
    exp_ack.push_back('{2'd2, 16'hBEEF, s + 18});
    wait_idle("host_busy");
    tick();
    m_regs[2] = 16'hBEEF;
    applyStimulus(0, 0, 0, 0, 2'b00, '0);
    checkOutput("host_busy_r2", {16'b0, rf[2]}, 32'hBEEF);

    // Start together with a host request: host wins, start is dropped.
    s = cyc;
    exp_ack.push_back('{2'd3, 16'h0A0A, s});
    m_regs[3] = 16'h0A0A;
    applyStimulus(1, 0, 0, 1, 2'd3, 16'h0A0A);
    tick();
    applyStimulus(0, 0, 0, 0, 2'b00, '0);
    checkOutput("host_start_busy", {31'b0, busy}, 32'd0);
    tick();
    tick();
    checkOutput("host_start_busy2", {31'b0, busy}, 32'd0);
    checkOutput("host_start_pc", {28'b0, pc}, {28'b0, m_pc});

    // Randomized mix of host writes, runs, halted runs and steps.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0: host_write(2'($urandom), 16'($urandom));
        1: do_run(0);
        2: do_run($urandom_range(1, 16));
        3: do_step();
        default: for (int i = 0; i < 4; i++) prog[i] = 8'($urandom);
      endcase
      tick();
    end

    // Long step sequence drives the retire counter into saturation.
    for (int i = 0; i < 260; i++) do_step();
    checkOutput("count_sat", {24'b0, instr_count}, 32'd255);

    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < exp_wr.size(); i++) report_unexpected("missing_wb");
    for (int i = 0; i < exp_ack.size(); i++) report_unexpected("missing_ack");
    for (int i = 0; i < exp_done.size(); i++) report_unexpected("missing_done");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
